// File: rtl/dmem_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_ctrl_if : MEM-stage request/response channel for dmem_ctrl     |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
interface dmem_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_ctrl : load/store controller for a 32-bit synchronous SRAM     |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
module dmem_ctrl #(
  parameter int ADDR_W = 14
) (
  input  wire               CK,
  input  wire               RSTB,
  dmem_ctrl_if.slave        bus,
  output logic              CS,
  output logic              OE,
  output logic [3:0]        WEB,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       DI,
  input  wire  [31:0]       DO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic        w_req_ready;
  logic        w_accept;
  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_req_ready = (r_state == S_IDLE) || ((r_state == S_RSP) && bus.resp_ready);
  // Reset gates acceptance so the SRAM never sees CS while RSTB is low.
  assign w_accept    = RSTB && bus.req_valid && w_req_ready;

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

  always_comb begin
    w_err = 1'b0;
    unique case (bus.req_funct3)
      3'b000:  w_err = 1'b0;
      3'b001:  w_err = bus.req_addr[0];
      3'b010:  w_err = (bus.req_addr[1:0] != 2'b00);
      3'b100:  w_err = bus.req_we;
      3'b101:  w_err = bus.req_we | bus.req_addr[0];
      default: w_err = 1'b1;
    endcase
  end

  assign w_byte = DO[{r_lane, 3'b000} +: 8];
  assign w_half = r_lane[1] ? DO[31:16] : DO[15:0];

  always_comb begin
    w_load_data = DO;
    unique case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = DO;
    endcase
  end

  always_comb begin
    CS  = 1'b0;
    OE  = (r_state == S_RD);
    WEB = 4'hF;
    A   = '0;
    DI  = '0;
    if (w_accept && !w_err) begin
      CS = 1'b1;
      A  = bus.req_addr[ADDR_W+1:2];
      if (bus.req_we) begin
        unique case (bus.req_funct3)
          3'b000: begin
            WEB = ~(4'b0001 << bus.req_addr[1:0]);
            DI  = {4{bus.req_wdata[7:0]}};
          end
          3'b001: begin
            WEB = bus.req_addr[1] ? 4'b0011 : 4'b1100;
            DI  = {2{bus.req_wdata[15:0]}};
          end
          default: begin
            WEB = 4'b0000;
            DI  = bus.req_wdata;
          end
        endcase
      end else begin
        OE = 1'b1;
      end
    end
  end

  always_ff @(posedge CK or negedge RSTB) begin
    if (!RSTB) begin
      r_state      <= S_IDLE;
      r_funct3     <= 3'b000;
      r_lane       <= 2'b00;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_RD: begin
          r_state      <= S_RSP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_load_data;
          r_resp_err   <= 1'b0;
        end
        S_IDLE, S_RSP: begin
          // A held response blocks everything until it is consumed.
          if (w_req_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            if (bus.req_valid) begin
              r_funct3 <= bus.req_funct3;
              r_lane   <= bus.req_addr[1:0];
              if (w_err) begin
                r_state      <= S_RSP;
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b1;
              end else if (!bus.req_we) begin
                r_state <= S_RD;
              end else begin
                r_state      <= S_RSP;
                r_resp_valid <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dmem_ctrl : directed-vector bench for dmem_ctrl with SRAM model  |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module tb_dmem_ctrl;

  logic        CK = 1'b0;
  logic        RSTB;
  logic        CS;
  logic        OE;
  logic [3:0]  WEB;
  logic [13:0] A;
  logic [31:0] DI;
  logic [31:0] DO;
  logic [31:0] mem [0:16383];
  int          n_tests;
  int          n_fail;

  dmem_ctrl_if #(.ADDR_W(14)) bus ();

  dmem_ctrl #(.ADDR_W(14)) dut (
    .CK   (CK),
    .RSTB (RSTB),
    .bus  (bus.slave),
    .CS   (CS),
    .OE   (OE),
    .WEB  (WEB),
    .A    (A),
    .DI   (DI),
    .DO   (DO)
  );

  always #5 CK = ~CK;

  // Synchronous SRAM: byte-masked write, read data one cycle after CS.
  always @(posedge CK) begin
    if (CS) begin
      for (int i = 0; i < 4; i++)
        if (!WEB[i]) mem[A][8*i +: 8] <= DI[8*i +: 8];
      DO <= mem[A];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input string name, input logic we, input logic [2:0] f3,
                      input logic [15:0] addr, input logic [31:0] wd,
                      input logic exp_cs, input logic [3:0] exp_web, input logic [31:0] exp_di);
    @(negedge CK);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    #1;
    check({name, ".req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({name, ".cs"},  {31'd0, CS}, {31'd0, exp_cs});
    check({name, ".oe"},  {31'd0, OE}, {31'd0, exp_cs & ~we});
    check({name, ".web"}, {28'd0, WEB}, {28'd0, exp_web});
    check({name, ".a"},   {18'd0, A}, exp_cs ? {18'd0, addr[15:2]} : 32'd0);
    check({name, ".di"},  DI, exp_di);
    @(posedge CK);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic expect_resp(input string name, input int lat,
                             input logic [31:0] rdata, input logic err);
    int n;
    n = 1;
    while (!bus.resp_valid && n < 8) begin
      @(posedge CK);
      #1;
      n++;
    end
    check({name, ".latency"}, n, lat);
    check({name, ".rdata"}, bus.resp_rdata, rdata);
    check({name, ".err"}, {31'd0, bus.resp_err}, {31'd0, err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    RSTB           = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 16'd0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b1;

    repeat (2) @(negedge CK);
    check("rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst.resp_rdata", bus.resp_rdata, 32'd0);
    check("rst.resp_err",   {31'd0, bus.resp_err}, 32'd0);
    check("rst.cs",  {31'd0, CS}, 32'd0);
    check("rst.web", {28'd0, WEB}, 32'hF);
    check("rst.a",   {18'd0, A}, 32'd0);
    RSTB = 1'b1;

    // Word, byte and halfword stores followed by read-back with extension
    send("sw10", 1'b1, 3'b010, 16'h0010, 32'hDEADBEEF, 1'b1, 4'b0000, 32'hDEADBEEF);
    expect_resp("sw10", 1, 32'd0, 1'b0);
    send("lw10", 1'b0, 3'b010, 16'h0010, 32'd0, 1'b1, 4'hF, 32'd0);
    expect_resp("lw10", 2, 32'hDEADBEEF, 1'b0);
    send("sb13", 1'b1, 3'b000, 16'h0013, 32'h00000080, 1'b1, 4'b0111, 32'h80808080);
    expect_resp("sb13", 1, 32'd0, 1'b0);
    send("lb13", 1'b0, 3'b000, 16'h0013, 32'd0, 1'b1, 4'hF, 32'd0);
    expect_resp("lb13", 2, 32'hFFFFFF80, 1'b0);
    send("lbu13", 1'b0, 3'b100, 16'h0013, 32'd0, 1'b1, 4'hF, 32'd0);
    expect_resp("lbu13", 2, 32'h00000080, 1'b0);
    send("sh22", 1'b1, 3'b001, 16'h0022, 32'h00008001, 1'b1, 4'b0011, 32'h80018001);
    expect_resp("sh22", 1, 32'd0, 1'b0);
    send("lh22", 1'b0, 3'b001, 16'h0022, 32'd0, 1'b1, 4'hF, 32'd0);
    expect_resp("lh22", 2, 32'hFFFF8001, 1'b0);
    send("lhu22", 1'b0, 3'b101, 16'h0022, 32'd0, 1'b1, 4'hF, 32'd0);
    expect_resp("lhu22", 2, 32'h00008001, 1'b0);

    // Illegal requests: no SRAM access, error response one cycle later
    send("lw11", 1'b0, 3'b010, 16'h0011, 32'd0, 1'b0, 4'hF, 32'd0);
    expect_resp("lw11", 1, 32'd0, 1'b1);
    send("sh01", 1'b1, 3'b001, 16'h0001, 32'h0000FFFF, 1'b0, 4'hF, 32'd0);
    expect_resp("sh01", 1, 32'd0, 1'b1);
    send("f3_011", 1'b0, 3'b011, 16'h0000, 32'd0, 1'b0, 4'hF, 32'd0);
    expect_resp("f3_011", 1, 32'd0, 1'b1);
    send("sbu", 1'b1, 3'b100, 16'h0000, 32'h000000AA, 1'b0, 4'hF, 32'd0);
    expect_resp("sbu", 1, 32'd0, 1'b1);

    // Back-pressure: held load response blocks a pending store
    send("bp_lw", 1'b0, 3'b010, 16'h0010, 32'd0, 1'b1, 4'hF, 32'd0);
    bus.resp_ready = 1'b0;
    expect_resp("bp_lw", 2, 32'h80ADBEEF, 1'b0);
    @(negedge CK);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 16'h0030;
    bus.req_wdata  = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("bp.resp_rdata", bus.resp_rdata, 32'h80ADBEEF);
      check("bp.req_ready",  {31'd0, bus.req_ready}, 32'd0);
      check("bp.cs",  {31'd0, CS}, 32'd0);
      check("bp.web", {28'd0, WEB}, 32'hF);
      @(negedge CK);
    end
    bus.resp_ready = 1'b1;
    #1;
    check("bp_sw.req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("bp_sw.cs",  {31'd0, CS}, 32'd1);
    check("bp_sw.web", {28'd0, WEB}, 32'h0);
    check("bp_sw.a",   {18'd0, A}, 32'h0000000C);
    check("bp_sw.di",  DI, 32'h12345678);
    @(posedge CK);
    #1;
    bus.req_valid = 1'b0;
    check("bp_sw.resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    check("bp_sw.resp_rdata", bus.resp_rdata, 32'd0);
    check("bp_sw.resp_err",   {31'd0, bus.resp_err}, 32'd0);
    send("lw30", 1'b0, 3'b010, 16'h0030, 32'd0, 1'b1, 4'hF, 32'd0);
    expect_resp("lw30", 2, 32'h12345678, 1'b0);
    send("lb31", 1'b0, 3'b000, 16'h0031, 32'd0, 1'b1, 4'hF, 32'd0);
    expect_resp("lb31", 2, 32'h00000056, 1'b0);

    // Reset asserted during the RD cycle of a load
    send("rst_lw", 1'b0, 3'b010, 16'h0010, 32'd0, 1'b1, 4'hF, 32'd0);
    check("rst_lw.oe_rd", {31'd0, OE}, 32'd1);
    #2;
    RSTB = 1'b0;
    #1;
    check("rst_rd.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_rd.cs",  {31'd0, CS}, 32'd0);
    check("rst_rd.oe",  {31'd0, OE}, 32'd0);
    check("rst_rd.web", {28'd0, WEB}, 32'hF);
    @(negedge CK);
    RSTB = 1'b1;
    @(posedge CK);
    #1;
    check("post_rst.req_ready",  {31'd0, bus.req_ready}, 32'd1);
    check("post_rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    repeat (2) @(posedge CK);
    #1;
    check("post_rst.no_resp", {31'd0, bus.resp_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the pipeline MEM stage and the 16K×32 synchronous SRAM wrapper. Accepts one load/store request at a time over a valid/ready handshake and drives the SRAM's CS/OE/WEB/A/DI pins. Generates byte-lane write masks with replicated write data, and captures the SRAM's one-cycle-late DO. Returns a sign- or zero-extended load result, or a store acknowledge, over a valid/ready response channel.

## Interface
- ADDR_W, 14, SRAM word-address width; byte address is ADDR_W+2 bits
- CK  in  1  clock; all state on rising edge
- RSTB  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
- req_addr  in  ADDR_W+2  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned address or illegal funct3
- CS  out  1  SRAM chip select
- OE  out  1  SRAM output enable
- WEB  out  4  SRAM per-byte write enable, active low; bit i covers DI[8i+7:8i]
- A  out  ADDR_W  SRAM word address = req_addr[ADDR_W+1:2]
- DI  out  32  SRAM write data
- DO  in  32  SRAM read data, valid the cycle after a read is issued

## Operation
- FSM states: IDLE, RD, RSP.
- req_ready = (state==IDLE) || (state==RSP && resp_ready).
- Error check on accept:
  - H/HU with addr[0]=1 is an error.
  - W with addr[1:0]≠0 is an error.
  - funct3 ∈ {011,110,111} is an error.
  - Store with funct3 100/101 is an error.
- Errored request: no SRAM access (CS=0). Next state RSP with resp_err=1, resp_rdata=0.
- Accepted legal load: CS=1, OE=1, WEB=4'hF, A from address. Next state RD.
- RD:
  - OE=1, CS=0.
  - Select the lane from the registered addr[1:0].
  - B/BU take DO[8·lane+7 : 8·lane]. H/HU take DO[16·addr[1]+15 : 16·addr[1]].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Register the result into resp_rdata, resp_err=0, next state RSP.
- Accepted legal store: CS=1, OE=0, A from address. Next state RSP with resp_rdata=0, resp_err=0.
  - SB: WEB = ~(4'b0001<<addr[1:0]), DI = {4{wdata[7:0]}}.
  - SH: WEB = addr[1] ? 4'b0011 : 4'b1100, DI = {2{wdata[15:0]}}.
  - SW: WEB = 4'b0000, DI = wdata.
- RSP:
  - resp_valid=1; response fields stay stable until consumed.
  - On resp_ready: a new request may be accepted in the same cycle, with the next state chosen as from IDLE. With no new request, the next state is IDLE.
- Default SRAM pins when not issuing: CS=0, OE=0 (except in RD), WEB=4'hF, A=0, DI=0.
- The SRAM pins are combinational from the request inputs in the acceptance cycle. The response outputs are registered.

## Timing
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, CS=0, OE=0, WEB=4'hF, A=0, DI=0.
- RSTB asserted forces CS=0 and WEB=4'hF immediately, so no write can occur. In-flight loads and held responses are discarded.
- Load latency: accept in cycle t, DO sampled in t+1, resp_valid in t+2.
- Store and error latency: accept in t, resp_valid in t+1. The SRAM write occurs at the edge ending t.
- Peak throughput with resp_ready held high: one store or error per cycle, one load per 2 cycles.
- Exactly one response per accepted request, in order.
- While resp_valid=1 and resp_ready=0, req_ready=0 and the SRAM pins stay idle.

## Test plan
- SW addr 0x0010 data 0xDEADBEEF, then LW 0x0010: SW drives CS=1, WEB=0000, A=4. LW resp_rdata=0xDEADBEEF two cycles after accept.
- SB 0x0013 data 0x80, then LB 0x0013 and LBU 0x0013: SB drives WEB=0111, DI=0x80808080. LB returns 0xFFFFFF80; LBU returns 0x00000080.
- SH 0x0022 data 0x8001, then LH 0x0022 and LHU 0x0022: SH drives WEB=0011. LH returns 0xFFFF8001; LHU returns 0x00008001.
- LW 0x0011, SH 0x0001, and funct3=011: each gives CS=0, resp_err=1, resp_rdata=0 one cycle after accept.
- Hold resp_ready=0 for 5 cycles after an LW: resp_valid and resp_rdata stay stable and req_ready=0. Raising resp_ready together with a pending SW accepts the SW in that same cycle.
- Assert RSTB=0 in the RD cycle of an LW: resp_valid=0 and CS=0 immediately. After release, state is IDLE and req_ready=1.
